// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use stall detection, bubble insertion, hold and flush.
module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter logic [3:0] NOP_OP = 4'b1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_imm,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_dest,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_first,
    output logic [DATA_W-1:0] alu_second,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic              stall_req
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              use_rs;
        logic              use_rt;
        logic              use_imm;
        logic [3:0]        op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } stage_t;

    stage_t q;
    stage_t d;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign d = '{valid: id_valid, rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm,
                 rs: id_rs, rt: id_rt, dest: id_dest, use_rs: id_use_rs, use_rt: id_use_rt,
                 use_imm: id_use_imm, op: id_alu_op, reg_write: id_reg_write,
                 mem_read: id_mem_read, mem_write: id_mem_write};

    // A load in EX cannot supply its data yet; one bubble lets it reach MEM/WB forwarding.
    assign stall_req = !flush && id_valid && q.valid && q.mem_read &&
                       ((id_use_rs && id_rs == q.dest) || (id_use_rt && id_rt == q.dest));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            q.op <= NOP_OP;
        end else if (flush || (!hold && stall_req)) begin
            q    <= '0;
            q.op <= NOP_OP;
        end else if (!hold) begin
            q <= d;
        end
    end

    assign opnd_a = (q.use_rs && exmem_reg_write && exmem_dest == q.rs) ? exmem_result :
                    (q.use_rs && memwb_reg_write && memwb_dest == q.rs) ? memwb_result : q.rdata1;
    assign opnd_b = (q.use_rt && exmem_reg_write && exmem_dest == q.rt) ? exmem_result :
                    (q.use_rt && memwb_reg_write && memwb_dest == q.rt) ? memwb_result : q.rdata2;

    assign alu_first     = q.valid ? opnd_a : '0;
    assign alu_second    = !q.valid ? '0 : q.use_imm ? q.imm : opnd_b;
    assign ex_store_data = q.valid ? opnd_b : '0;
    assign alu_op        = q.valid ? q.op : NOP_OP;
    assign ex_dest       = q.dest;
    assign ex_reg_write  = q.valid && q.reg_write;
    assign ex_mem_read   = q.valid && q.mem_read;
    assign ex_mem_write  = q.valid && q.mem_write;
    assign ex_valid      = q.valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: table-driven vectors plus hand sequences for stall, hold, flush and
// async reset; expected outputs flow through a scoreboard queue.
module tb_id_ex_operand_stage;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct {
        logic [15:0] first;
        logic [15:0] second;
        logic [15:0] store;
        logic [3:0]  op;
        logic [3:0]  dest;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        stall;
    } exp_t;

    typedef struct {
        logic        v;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        urs;
        logic        urt;
        logic        uimm;
        logic [3:0]  op;
        logic [3:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  xd;
        logic        xw;
        logic [15:0] xr;
        logic [3:0]  wd;
        logic        ww;
        logic [15:0] wr;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst, hold, flush;
    logic id_valid, id_use_rs, id_use_rt, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [15:0] id_rdata1, id_rdata2, id_imm, exmem_result, memwb_result;
    logic [3:0] id_rs, id_rt, id_alu_op, id_dest, exmem_dest, memwb_dest;
    logic exmem_reg_write, memwb_reg_write;
    logic [15:0] alu_first, alu_second, ex_store_data;
    logic [3:0] alu_op, ex_dest;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, stall_req;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vecs[8];
    vec_t ld, dep;
    exp_t bub, ld_e, ld_stall_e, dep_e;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .exmem_dest(exmem_dest), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_dest(memwb_dest), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result), .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_valid(ex_valid),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".alu_first"}, alu_first, e.first);
        chk({tag, ".alu_second"}, alu_second, e.second);
        chk({tag, ".store_data"}, ex_store_data, e.store);
        chk({tag, ".alu_op"}, 16'(alu_op), 16'(e.op));
        chk({tag, ".ex_dest"}, 16'(ex_dest), 16'(e.dest));
        chk({tag, ".ex_valid"}, 16'(ex_valid), 16'(e.valid));
        chk({tag, ".reg_write"}, 16'(ex_reg_write), 16'(e.rw));
        chk({tag, ".mem_read"}, 16'(ex_mem_read), 16'(e.mr));
        chk({tag, ".mem_write"}, 16'(ex_mem_write), 16'(e.mw));
        chk({tag, ".stall_req"}, 16'(stall_req), 16'(e.stall));
    endtask

    task automatic set_id(input vec_t v);
        id_valid = v.v; id_rdata1 = v.rd1; id_rdata2 = v.rd2; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt; id_use_imm = v.uimm;
        id_alu_op = v.op; id_dest = v.dest; id_reg_write = v.rw; id_mem_read = v.mr;
        id_mem_write = v.mw;
    endtask

    task automatic set_fwd(input vec_t v);
        exmem_dest = v.xd; exmem_reg_write = v.xw; exmem_result = v.xr;
        memwb_dest = v.wd; memwb_reg_write = v.ww; memwb_result = v.wr;
    endtask

    initial begin
        bub = '{16'h0, 16'h0, 16'h0, 4'h8, 4'd0, F, F, F, F, F};
        vecs[0] = '{T, 16'h0003, 16'h0005, 16'h0000, 4'd1, 4'd2, T, T, F, 4'h0, 4'd2, T, F, F,
                    4'd0, F, 16'h0, 4'd0, F, 16'h0,
                    '{16'h0003, 16'h0005, 16'h0005, 4'h0, 4'd2, T, T, F, F, F}};
        vecs[1] = '{T, 16'h0001, 16'h0007, 16'h0000, 4'd1, 4'd3, T, T, F, 4'h1, 4'd5, T, F, F,
                    4'd1, T, 16'h1234, 4'd1, T, 16'hBEEF,
                    '{16'h1234, 16'h0007, 16'h0007, 4'h1, 4'd5, T, T, F, F, F}};
        vecs[2] = '{T, 16'h0001, 16'h0007, 16'h0000, 4'd1, 4'd3, T, T, F, 4'h1, 4'd5, T, F, F,
                    4'd1, F, 16'h1234, 4'd1, T, 16'hBEEF,
                    '{16'hBEEF, 16'h0007, 16'h0007, 4'h1, 4'd5, T, T, F, F, F}};
        vecs[3] = '{T, 16'h0A0A, 16'h1111, 16'h00FF, 4'd7, 4'd6, T, T, T, 4'h2, 4'd0, F, F, T,
                    4'd6, T, 16'h5555, 4'd7, T, 16'h7777,
                    '{16'h7777, 16'h00FF, 16'h5555, 4'h2, 4'd0, T, F, F, T, F}};
        vecs[4] = '{T, 16'h0042, 16'h0024, 16'h0000, 4'd2, 4'd4, F, T, F, 4'h3, 4'd7, T, F, F,
                    4'd2, T, 16'h9999, 4'd4, T, 16'h4444,
                    '{16'h0042, 16'h4444, 16'h4444, 4'h3, 4'd7, T, T, F, F, F}};
        vecs[5] = '{F, 16'h1111, 16'h2222, 16'h3333, 4'd1, 4'd2, T, T, F, 4'h4, 4'd0, T, T, T,
                    4'd1, T, 16'h5555, 4'd2, T, 16'h6666, bub};
        vecs[6] = '{T, 16'h0101, 16'h0202, 16'h0000, 4'd5, 4'd3, T, T, F, 4'h5, 4'd6, T, F, F,
                    4'd3, T, 16'hABCD, 4'd5, F, 16'hEEEE,
                    '{16'h0101, 16'hABCD, 16'hABCD, 4'h5, 4'd6, T, T, F, F, F}};
        vecs[7] = '{T, 16'h0F0F, 16'h3C3C, 16'h8000, 4'd1, 4'd1, T, T, T, 4'h6, 4'd3, T, F, F,
                    4'd2, T, 16'h0001, 4'd1, T, 16'h2468,
                    '{16'h2468, 16'h8000, 16'h2468, 4'h6, 4'd3, T, T, F, F, F}};
        ld  = '{T, 16'h0010, 16'h0000, 16'h0004, 4'd1, 4'd0, T, F, T, 4'h0, 4'd4, T, T, F,
                4'd0, F, 16'h0, 4'd0, F, 16'h0, bub};
        dep = '{T, 16'h0020, 16'h0000, 16'h0000, 4'd2, 4'd4, T, T, F, 4'h1, 4'd5, T, F, F,
                4'd0, F, 16'h0, 4'd4, T, 16'hCAFE, bub};
        ld_e       = '{16'h0010, 16'h0004, 16'h0000, 4'h0, 4'd4, T, T, T, F, F};
        ld_stall_e = '{16'h0010, 16'h0004, 16'h0000, 4'h0, 4'd4, T, T, T, F, T};
        dep_e      = '{16'h0020, 16'hCAFE, 16'hCAFE, 4'h1, 4'd5, T, T, F, F, F};

        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        set_id(vecs[5]); id_valid = 1'b0;
        set_fwd(ld);
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(bub); check_out("reset");
        rst = 1'b1;
        tick();
        sb.push_back(bub); check_out("reset_release");

        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i]);
            sb.push_back(vecs[i].e);
            tick();
            set_fwd(vecs[i]);
            #1;
            check_out($sformatf("vec%0d", i));
        end

        set_id(ld); set_fwd(ld);
        tick();
        sb.push_back(ld_e); check_out("load_in_ex");
        set_id(dep);
        #1;
        sb.push_back(ld_stall_e); check_out("load_use_stall");
        tick();
        sb.push_back(bub); check_out("load_use_bubble");
        tick();
        set_fwd(dep);
        #1;
        sb.push_back(dep_e); check_out("load_use_fwd");

        set_id(ld); set_fwd(ld);
        tick();
        set_id(dep); flush = 1'b1;
        #1;
        sb.push_back(ld_e); check_out("flush_masks_stall");
        tick();
        flush = 1'b0;
        sb.push_back(bub); check_out("flush_bubble");

        set_id(vecs[0]); set_fwd(vecs[0]);
        tick();
        sb.push_back(vecs[0].e); check_out("pre_hold");
        hold = 1'b1;
        set_id(vecs[6]);
        for (int i = 0; i < 3; i++) begin
            tick();
            sb.push_back(vecs[0].e); check_out($sformatf("hold%0d", i));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.push_back(bub); check_out("hold_flush");
        hold = 1'b0;
        set_id(vecs[3]);
        tick();
        set_fwd(vecs[3]);
        hold = 1'b1;
        #1;
        sb.push_back(vecs[3].e); check_out("reload");
        tick();
        sb.push_back(vecs[3].e); check_out("reload_hold");
        rst = 1'b0;
        #1;
        sb.push_back(bub); check_out("async_rst_mid_hold");
        rst = 1'b1; hold = 1'b0;
        tick();
        sb.push_back(vecs[3].e); check_out("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end that drives the EX-stage ALU's first, second and op inputs.
- Latches decoded instructions and resolves EX/MEM and MEM/WB forwarding on the registered source addresses.
- Detects load-use hazards, inserts bubbles, and honours pipeline hold and flush.

Parameters:
- DATA_W, 16, datapath width of operands, immediates and results.
- REG_AW, 4, register-address width; covers 8 GPRs plus special registers.
- NOP_OP, 4'b1000, ALU op code driven for bubbles (ALU result forced to zero).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze (memory busy); stage register keeps its value.
- flush  in  1  branch/jump redirect; the next stage content becomes a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_rdata1  in  DATA_W  register-file read port 1.
- id_rdata2  in  DATA_W  register-file read port 2.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_rs  in  REG_AW  source-1 address.
- id_rt  in  REG_AW  source-2 address.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_use_imm  in  1  ALU second operand is the immediate.
- id_alu_op  in  4  ALU operation code.
- id_dest  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- id_mem_write  in  1  instruction is a store.
- exmem_dest  in  REG_AW  EX/MEM destination.
- exmem_reg_write  in  1  EX/MEM writes the register file.
- exmem_result  in  DATA_W  EX/MEM ALU result.
- memwb_dest  in  REG_AW  MEM/WB destination.
- memwb_reg_write  in  1  MEM/WB writes the register file.
- memwb_result  in  DATA_W  MEM/WB writeback value.
- alu_first  out  DATA_W  to ALU first.
- alu_second  out  DATA_W  to ALU second.
- alu_op  out  4  to ALU op.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- ex_dest  out  REG_AW  registered destination.
- ex_reg_write  out  1  registered reg-write, gated by valid.
- ex_mem_read  out  1  registered load flag, gated by valid.
- ex_mem_write  out  1  registered store flag, gated by valid.
- ex_valid  out  1  EX slot holds a real instruction.
- stall_req  out  1  load-use hazard; IF/ID must hold this cycle.

Behaviour:
- Reset (rst=0, async):
  - Stage register is cleared to a bubble: valid=0, op=NOP_OP, all data/address fields 0, all control flags 0.
  - Outputs after reset: alu_first=0, alu_second=0, alu_op=NOP_OP, ex_store_data=0, ex_dest=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_valid=0, stall_req=0.
  - Reset mid-hold or mid-flush discards the in-flight instruction.
- Per-edge update priority: flush > hold > stall_req > load.
  - flush=1: load bubble, even if hold=1.
  - hold=1, flush=0: keep the register unchanged.
  - stall_req=1: load bubble; the IF/ID instruction is re-presented next cycle.
  - Otherwise: load the id_* fields, with valid=id_valid.
- stall_req (combinational):
  - Asserts when ex_valid & ex_mem_read & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)) & id_valid.
  - Forced to 0 when flush=1.
  - Deasserts after exactly one bubble, because the load has moved to MEM.
- Forwarding (combinational on registered rs/rt, zero added latency):
  - Operand A = exmem_result if use_rs & exmem_reg_write & exmem_dest==rs.
  - Else memwb_result if use_rs & memwb_reg_write & memwb_dest==rs.
  - Else registered rdata1.
  - Operand B is resolved the same way on rt and rdata2.
  - EX/MEM always has priority over MEM/WB.
- alu_first = operand A.
- alu_second = registered imm if use_imm, else operand B.
- ex_store_data = operand B, always forwarded, independent of use_imm.
- Bubble outputs: valid=0 forces alu_op=NOP_OP and all write/mem flags to 0. alu_first/alu_second are don't-care but deterministic (0).
- Latency: an instruction accepted at edge N appears on the outputs after edge N until the next non-hold edge.

Test Plan:
- Reset release, no instruction:
  - Stimulus: id_valid=0.
  - Required: alu_op=4'b1000, ex_valid=0, ex_reg_write=0, stall_req=0.
- Plain register ADD, no hazard:
  - Stimulus: rdata1=0x0003, rdata2=0x0005, op=0000, dest=2.
  - Required: next cycle alu_first=0x0003, alu_second=0x0005, ex_dest=2, ex_valid=1.
- Double-hit forwarding priority:
  - Stimulus: EX rs=1; exmem_dest=1 / exmem_result=0x1234; memwb_dest=1 / memwb_result=0xBEEF, both writing.
  - Required: alu_first=0x1234. Dropping exmem_reg_write gives 0xBEEF.
- Load-use:
  - Stimulus: EX holds a load to r4; ID uses rt=4.
  - Required: stall_req=1 for one cycle; next EX is a bubble (ex_valid=0, op=1000); the following cycle loads the dependent instruction with memwb forwarding of the load data.
- Immediate with store:
  - Stimulus: use_imm=1, imm=0x00FF, rt forwarded from exmem=0x5555.
  - Required: alu_second=0x00FF, ex_store_data=0x5555.
- Hold + flush interaction:
  - Stimulus: hold=1 for 3 cycles.
  - Required: outputs frozen. Then hold=1 & flush=1 gives a bubble on the next edge. rst pulsed low mid-hold clears asynchronously without a clock edge.
